// File: rtl/tone_player.sv
// tone_player: song-table square-wave tone player; ports clk, reset, addr_in[3:0], octave_up (only with TONE_OCTAVE_EN), tone_out, note_code[3:0], playing
module tone_player #(
  parameter int PRESCALE = 1,
  parameter int GAP_CYCLES = 1000,
  parameter logic [63:0] SONG = 64'h0A98_5355_8A98_5351
) (
  input logic clk,
  input logic reset,
  input logic [3:0] addr_in,
`ifdef TONE_OCTAVE_EN
  input logic octave_up,
`endif
  output logic tone_out,
  output logic [3:0] note_code,
  output logic playing
);
  typedef enum logic [1:0] {IDLE, GAP, PLAY, REST} state_t;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [175:0] HP_TAB = {
    11'd851, 11'd902, 11'd956, 11'd1012, 11'd1073, 11'd1136, 11'd1204, 11'd1276,
    11'd1351, 11'd1432, 11'd1517, 11'd1607, 11'd1703, 11'd1804, 11'd1911, 11'd0};
  state_t state;
  logic [3:0] addr_q, code;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] pcnt;
  logic [10:0] cnt, hp_q, hp;
  logic load, tick;
  always_comb begin
    code = SONG[4*addr_in +: 4];
`ifdef TONE_OCTAVE_EN
    hp = HP_TAB[11*code +: 11] >> octave_up;
`else
    hp = HP_TAB[11*code +: 11];
`endif
    load = state == IDLE || addr_in != addr_q;
    tick = pcnt == PW'(PRESCALE - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      gap_cnt <= '0;
      pcnt <= '0;
      cnt <= '0;
      hp_q <= '0;
      tone_out <= 1'b0;
      note_code <= '0;
      playing <= 1'b0;
    end else if (load) begin
      addr_q <= addr_in;
      note_code <= code;
      hp_q <= hp;
      tone_out <= 1'b0;
      playing <= GAP_CYCLES == 0 && code != 0;
      gap_cnt <= '0;
      cnt <= '0;
      pcnt <= '0;
      state <= GAP_CYCLES > 0 ? GAP : (code != 0 ? PLAY : REST);
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
      if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
        state <= note_code != 0 ? PLAY : REST;
        playing <= note_code != 0;
      end
    end else if (state == PLAY) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        cnt <= cnt == hp_q - 11'd1 ? '0 : cnt + 11'd1;
        tone_out <= cnt == hp_q - 11'd1 ? ~tone_out : tone_out;
      end
    end
  end
endmodule
